// File: rtl/v35_pic_n_pkg.sv
// Shared types and constants for the v35_pic_n interrupt controller.
//   pic_state_t : handshake state (IDLE / PEND / ACK1)
//   pic_src_t   : source of the latched grant (NMI / INT / EXIC channel)
//   EXIC_*      : bit positions inside one 8-bit EXIC channel byte
package v35_pic_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK1 = 2'd2
  } pic_state_t;

  typedef enum logic [1:0] {
    SRC_NMI  = 2'd0,
    SRC_INT  = 2'd1,
    SRC_EXIC = 2'd2
  } pic_src_t;

  localparam int unsigned EXIC_IF_BIT   = 7;
  localparam int unsigned EXIC_MK_BIT   = 6;
  localparam int unsigned EXIC_PRIO_LSB = 0;
  localparam int unsigned PRIO_W        = 3;
  localparam int unsigned BYTE_W        = 8;

  // Width of a channel index; never below one bit so single-channel builds stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/v35_pic_arbiter.sv
// Combinational EXIC channel arbiter.
//   exic  : NUM_EXIC channel bytes (IF, MK, 3-bit priority)
//   ispr  : current in-service priority register
//   valid : at least one channel is eligible
//   idx   : winning channel (lowest priority value, then lowest index)
//   prio  : priority of the winning channel
module v35_pic_arbiter
  import v35_pic_n_pkg::*;
#(
  parameter int unsigned NUM_EXIC = 3,
  localparam int unsigned IDX_W   = idx_width(NUM_EXIC)
) (
  input  logic [BYTE_W*NUM_EXIC-1:0] exic,
  input  logic [BYTE_W-1:0]          ispr,
  output logic                       valid,
  output logic [IDX_W-1:0]           idx,
  output logic [PRIO_W-1:0]          prio
);

  logic [BYTE_W-1:0] ch_c;
  logic [PRIO_W-1:0] ch_prio_c;
  logic [BYTE_W-1:0] blk_mask_c;
  logic              unused_c;

  // Reserved channel bits are not decoded.
  assign unused_c = ^exic;

  // A channel is blocked while any in-service level at or above its own is active.
  always_comb begin
    valid      = 1'b0;
    idx        = '0;
    prio       = '0;
    ch_c       = '0;
    ch_prio_c  = '0;
    blk_mask_c = '0;
    for (int unsigned k = 0; k < NUM_EXIC; k++) begin
      ch_c       = exic[BYTE_W*k +: BYTE_W];
      ch_prio_c  = ch_c[EXIC_PRIO_LSB +: PRIO_W];
      blk_mask_c = BYTE_W'((9'd2 << ch_prio_c) - 9'd1);
      // Strict compare keeps the lower index on equal priority.
      if (ch_c[EXIC_IF_BIT] && !ch_c[EXIC_MK_BIT] &&
          ((ispr & blk_mask_c) == 8'd0) && (!valid || (ch_prio_c < prio))) begin
        valid = 1'b1;
        idx   = IDX_W'(k);
        prio  = ch_prio_c;
      end
    end
  end

endmodule

// File: rtl/v35_pic_n.sv
// Parametrised V35-class interrupt controller (NMI, INT pin, NUM_EXIC EXIC channels).
//   clk, reset (sync, active-high), ce (clock enable)
//   nmi, intp, int_vec_ext, exic, ie : request sources and CPU enable
//   fint     : end-of-interrupt, retires lowest set ISPR bit
//   int_ack  : two-pulse CPU acknowledge
//   int_req  : interrupt pending to CPU (PEND/ACK1)
//   int_vector, ispr : granted vector and in-service register
//   nmi_clear, int_clear, exic_clear : one-clk request clear pulses
module v35_pic_n
  import v35_pic_n_pkg::*;
#(
  parameter int unsigned NUM_EXIC    = 3,
  parameter int unsigned VECTOR_BASE = 24,
  parameter int unsigned NMI_VECTOR  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic                       nmi,
  input  logic                       intp,
  input  logic [BYTE_W-1:0]          int_vec_ext,
  input  logic [BYTE_W*NUM_EXIC-1:0] exic,
  input  logic                       ie,
  input  logic                       fint,
  input  logic                       int_ack,
  output logic                       int_req,
  output logic [BYTE_W-1:0]          int_vector,
  output logic [BYTE_W-1:0]          ispr,
  output logic                       nmi_clear,
  output logic                       int_clear,
  output logic [NUM_EXIC-1:0]        exic_clear
);

  localparam int unsigned IDX_W = idx_width(NUM_EXIC);
  localparam logic [BYTE_W-1:0] VEC_BASE = BYTE_W'(VECTOR_BASE);
  localparam logic [BYTE_W-1:0] VEC_NMI  = BYTE_W'(NMI_VECTOR);

  pic_state_t          state_q, state_d;
  pic_src_t            src_q, src_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PRIO_W-1:0]   prio_q, prio_d;
  logic                ack_prev_q, ack_prev_d;
  logic [BYTE_W-1:0]   ispr_q, ispr_d;
  logic [BYTE_W-1:0]   int_vector_q, int_vector_d;
  logic                int_req_q, int_req_d;
  logic                nmi_clear_q, nmi_clear_d;
  logic                int_clear_q, int_clear_d;
  logic [NUM_EXIC-1:0] exic_clear_q, exic_clear_d;

  logic                arb_valid_c;
  logic [IDX_W-1:0]    arb_idx_c;
  logic [PRIO_W-1:0]   arb_prio_c;
  logic                ack_edge_c;
  logic [BYTE_W-1:0]   ispr_nxt_c;

  v35_pic_arbiter #(
    .NUM_EXIC (NUM_EXIC)
  ) u_arb (
    .exic  (exic),
    .ispr  (ispr_q),
    .valid (arb_valid_c),
    .idx   (arb_idx_c),
    .prio  (arb_prio_c)
  );

  assign ack_edge_c = int_ack & ~ack_prev_q;

  // State register and all output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= SRC_NMI;
      idx_q        <= '0;
      prio_q       <= '0;
      ack_prev_q   <= 1'b0;
      ispr_q       <= '0;
      int_vector_q <= '0;
      int_req_q    <= 1'b0;
      nmi_clear_q  <= 1'b0;
      int_clear_q  <= 1'b0;
      exic_clear_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      idx_q        <= idx_d;
      prio_q       <= prio_d;
      ack_prev_q   <= ack_prev_d;
      ispr_q       <= ispr_d;
      int_vector_q <= int_vector_d;
      int_req_q    <= int_req_d;
      nmi_clear_q  <= nmi_clear_d;
      int_clear_q  <= int_clear_d;
      exic_clear_q <= exic_clear_d;
    end
  end

  // Next-state, grant latching, vector load and ISPR update.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    idx_d        = idx_q;
    prio_d       = prio_q;
    ack_prev_d   = ack_prev_q;
    ispr_d       = ispr_q;
    int_vector_d = int_vector_q;
    // Clears default low every clk so pulses end even when ce is low.
    nmi_clear_d  = 1'b0;
    int_clear_d  = 1'b0;
    exic_clear_d = '0;
    ispr_nxt_c   = ispr_q;

    if (ce) begin
      ack_prev_d = int_ack;
      // Retire the lowest in-service bit before any new set is ORed in.
      if (fint) begin
        ispr_nxt_c = ispr_q & (ispr_q - 8'd1);
      end

      case (state_q)
        IDLE: begin
          if (nmi) begin
            src_d   = SRC_NMI;
            state_d = PEND;
          end else if (intp && ie) begin
            src_d   = SRC_INT;
            state_d = PEND;
          end else if (ie && arb_valid_c) begin
            src_d   = SRC_EXIC;
            idx_d   = arb_idx_c;
            prio_d  = arb_prio_c;
            state_d = PEND;
          end
        end
        PEND: begin
          if (ack_edge_c) begin
            state_d = ACK1;
            case (src_q)
              SRC_NMI: begin
                nmi_clear_d  = 1'b1;
                int_vector_d = VEC_NMI;
              end
              SRC_INT: begin
                int_clear_d  = 1'b1;
                int_vector_d = int_vec_ext;
              end
              SRC_EXIC: begin
                exic_clear_d = NUM_EXIC'(1) << idx_q;
                int_vector_d = VEC_BASE + BYTE_W'(idx_q);
                ispr_nxt_c   = ispr_nxt_c | (8'd1 << prio_q);
              end
              default: begin
                state_d = IDLE;
              end
            endcase
          end
        end
        ACK1: begin
          if (ack_edge_c) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      ispr_d = ispr_nxt_c;
    end

    int_req_d = (state_d != IDLE);
  end

  assign int_req    = int_req_q;
  assign int_vector = int_vector_q;
  assign ispr       = ispr_q;
  assign nmi_clear  = nmi_clear_q;
  assign int_clear  = int_clear_q;
  assign exic_clear = exic_clear_q;

endmodule

// File: tb/tb_v35_pic_n.sv
// Directed bench for v35_pic_n with a queue of expected grant results.
module tb_v35_pic_n;

  localparam int unsigned N = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           ce;
  logic           nmi;
  logic           intp;
  logic [7:0]     int_vec_ext;
  logic [8*N-1:0] exic;
  logic           ie;
  logic           fint;
  logic           int_ack;
  logic           int_req;
  logic [7:0]     int_vector;
  logic [7:0]     ispr;
  logic           nmi_clear;
  logic           int_clear;
  logic [N-1:0]   exic_clear;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]   vec;
    logic [7:0]   ispr;
    logic         nmi_c;
    logic         int_c;
    logic [N-1:0] exic_c;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_ispr;

  v35_pic_n #(
    .NUM_EXIC    (N),
    .VECTOR_BASE (24),
    .NMI_VECTOR  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .nmi         (nmi),
    .intp        (intp),
    .int_vec_ext (int_vec_ext),
    .exic        (exic),
    .ie          (ie),
    .fint        (fint),
    .int_ack     (int_ack),
    .int_req     (int_req),
    .int_vector  (int_vector),
    .ispr        (ispr),
    .nmi_clear   (nmi_clear),
    .int_clear   (int_clear),
    .exic_clear  (exic_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: drop the lowest set bit by scanning.
  function automatic logic [7:0] m_fint(input logic [7:0] x);
    logic [7:0] r;
    logic       done;
    r    = x;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!done && r[i]) begin
        r[i] = 1'b0;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic set_ch(input int k, input logic rq, input logic mk, input logic [2:0] pr);
    exic[8*k +: 8] = {rq, mk, 3'b000, pr};
  endtask

  task automatic push_exic(input int idx, input int pr, input logic fint_at_ack);
    exp_t e;
    e.vec    = 8'(24 + idx);
    e.nmi_c  = 1'b0;
    e.int_c  = 1'b0;
    e.exic_c = '0;
    e.exic_c[idx] = 1'b1;
    e.ispr   = fint_at_ack ? m_fint(m_ispr) : m_ispr;
    e.ispr[pr] = 1'b1;
    m_ispr   = e.ispr;
    sb.push_back(e);
  endtask

  task automatic push_src(input logic is_nmi, input logic [7:0] vec);
    exp_t e;
    e.vec    = vec;
    e.nmi_c  = is_nmi;
    e.int_c  = !is_nmi;
    e.exic_c = '0;
    e.ispr   = m_ispr;
    sb.push_back(e);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (int_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(int_req), 32'd1);
  endtask

  task automatic first_ack(input string tag, input logic fint_on);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{vec: 8'h0, ispr: 8'h0, nmi_c: 1'b0, int_c: 1'b0, exic_c: '0};
    int_ack = 1'b1;
    fint    = fint_on;
    tick();
    fint = 1'b0;
    chk({tag, "_nmi_clr"},  32'(nmi_clear),  32'(e.nmi_c));
    chk({tag, "_int_clr"},  32'(int_clear),  32'(e.int_c));
    chk({tag, "_exic_clr"}, 32'(exic_clear), 32'(e.exic_c));
    chk({tag, "_vec"},      32'(int_vector), 32'(e.vec));
    chk({tag, "_ispr"},     32'(ispr),       32'(e.ispr));
    if (e.nmi_c) nmi = 1'b0;
    if (e.int_c) intp = 1'b0;
    for (int k = 0; k < int'(N); k++) if (e.exic_c[k]) exic[8*k+7] = 1'b0;
    tick();
    chk({tag, "_clr_off"}, 32'({nmi_clear, int_clear, exic_clear}), 32'd0);
    chk({tag, "_req_held"}, 32'(int_req), 32'd1);
  endtask

  task automatic second_ack(input string tag);
    tick();
    chk({tag, "_ack_level"}, 32'(int_req), 32'd1);
    int_ack = 1'b0;
    tick();
    int_ack = 1'b1;
    tick();
    chk({tag, "_req_drop"}, 32'(int_req), 32'd0);
    int_ack = 1'b0;
    tick();
  endtask

  task automatic fint_pulse(input string tag);
    fint = 1'b1;
    tick();
    fint   = 1'b0;
    m_ispr = m_fint(m_ispr);
    chk({tag, "_ispr"}, 32'(ispr), 32'(m_ispr));
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; nmi = 1'b0; intp = 1'b0; int_vec_ext = 8'h00;
    exic = '0; ie = 1'b0; fint = 1'b0; int_ack = 1'b0; m_ispr = 8'h00;
    tick();
    tick();
    chk("rst_req",  32'(int_req),    32'd0);
    chk("rst_ispr", 32'(ispr),       32'd0);
    chk("rst_vec",  32'(int_vector), 32'd0);
    chk("rst_clr",  32'({nmi_clear, int_clear, exic_clear}), 32'd0);
    reset = 1'b0;
    tick();

    // Ack edge in IDLE is ignored.
    int_ack = 1'b1;
    tick();
    chk("idle_ack_clr", 32'({nmi_clear, int_clear, exic_clear}), 32'd0);
    chk("idle_ack_req", 32'(int_req), 32'd0);
    int_ack = 1'b0;
    tick();

    // Single channel: ch1 prio 5.
    ie = 1'b1;
    set_ch(1, 1'b1, 1'b0, 3'd5);
    push_exic(1, 5, 1'b0);
    tick();
    chk("t1_req_1ce", 32'(int_req), 32'd1);
    first_ack("t1", 1'b0);
    second_ack("t1");
    fint_pulse("t1_fint");

    // Priority arbitration and ISPR blocking.
    set_ch(0, 1'b1, 1'b0, 3'd6);
    set_ch(2, 1'b1, 1'b0, 3'd2);
    push_exic(2, 2, 1'b0);
    wait_req("t2");
    first_ack("t2", 1'b0);
    second_ack("t2");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_blocked", 32'(int_req), 32'd0);
    end
    fint_pulse("t2_fint");
    chk("t2_still_idle", 32'(int_req), 32'd0);
    push_exic(0, 6, 1'b0);
    tick();
    chk("t2b_req", 32'(int_req), 32'd1);
    first_ack("t2b", 1'b0);
    second_ack("t2b");
    fint_pulse("t2b_fint");

    // NMI wins over INT with ie=0.
    ie = 1'b0; nmi = 1'b1; intp = 1'b1;
    push_src(1'b1, 8'd2);
    wait_req("t3");
    first_ack("t3", 1'b0);
    second_ack("t3");
    tick();
    chk("t3_int_masked", 32'(int_req), 32'd0);
    intp = 1'b0;

    // INT with external vector; ce gating delays the grant.
    ie = 1'b1; int_vec_ext = 8'h40; ce = 1'b0; intp = 1'b1;
    tick();
    tick();
    chk("t4_ce_hold", 32'(int_req), 32'd0);
    ce = 1'b1;
    push_src(1'b0, 8'h40);
    tick();
    chk("t4_req", 32'(int_req), 32'd1);
    first_ack("t4", 1'b0);
    int_vec_ext = 8'h55;
    second_ack("t4");
    chk("t4_vec_hold", 32'(int_vector), 32'h40);

    // Build ISPR, then fint coinciding with a grant.
    set_ch(0, 1'b1, 1'b0, 3'd3);
    push_exic(0, 3, 1'b0);
    wait_req("t5a");
    first_ack("t5a", 1'b0);
    second_ack("t5a");
    set_ch(1, 1'b1, 1'b0, 3'd2);
    push_exic(1, 2, 1'b0);
    wait_req("t5b");
    first_ack("t5b", 1'b0);
    second_ack("t5b");
    set_ch(2, 1'b1, 1'b0, 3'd1);
    push_exic(2, 1, 1'b1);
    wait_req("t5c");
    first_ack("t5c", 1'b1);
    second_ack("t5c");
    fint_pulse("t5_fint1");
    fint_pulse("t5_fint2");

    // Reset in ACK1 abandons the grant.
    set_ch(0, 1'b1, 1'b0, 3'd4);
    push_exic(0, 4, 1'b0);
    wait_req("t6");
    first_ack("t6", 1'b0);
    reset = 1'b1;
    int_ack = 1'b0;
    tick();
    m_ispr = 8'h00;
    chk("t6_rst_req",  32'(int_req), 32'd0);
    chk("t6_rst_ispr", 32'(ispr),    32'd0);
    chk("t6_rst_clr",  32'({nmi_clear, int_clear, exic_clear}), 32'd0);
    reset = 1'b0;
    tick();
    chk("t6_idle", 32'(int_req), 32'd0);
    set_ch(2, 1'b1, 1'b0, 3'd0);
    push_exic(2, 0, 1'b0);
    wait_req("t6b");
    first_ack("t6b", 1'b0);
    second_ack("t6b");
    fint_pulse("t6b_fint");

    // Reset coinciding with the first ack edge in PEND: no clear.
    set_ch(1, 1'b1, 1'b0, 3'd7);
    push_exic(1, 7, 1'b0);
    wait_req("t7");
    reset = 1'b1;
    int_ack = 1'b1;
    tick();
    chk("t7_rst_clr", 32'({nmi_clear, int_clear, exic_clear}), 32'd0);
    chk("t7_rst_req", 32'(int_req), 32'd0);
    reset = 1'b0;
    int_ack = 1'b0;
    tick();
    chk("t7_regrant", 32'(int_req), 32'd1);
    first_ack("t7", 1'b0);
    second_ack("t7");
    fint_pulse("t7_fint");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v35_pic_n.md
# v35_pic_n

Parametrised successor interrupt controller for the V35-class CPU core, serving NMI, the external INT pin and `NUM_EXIC` EXIC-style request channels. It sits between the peripheral and interrupt-flag registers and the CPU's interrupt sequencer. It differs from the fixed three-channel controller in four ways:
- per-channel priority arbitration;
- ISPR update using the granted channel's own priority;
- an externally supplied INT vector;
- a configurable vector base.

## Interface
Parameters:
- `NUM_EXIC`, 3, number of EXIC channels (1..8).
- `VECTOR_BASE`, 24, vector of channel 0; channel k uses `VECTOR_BASE+k` (8-bit, wraps modulo 256).
- `NMI_VECTOR`, 2, vector issued for NMI.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: clock enable; all state advances only when `ce`=1.
- `nmi` in 1: NMI request level, already latched upstream.
- `intp` in 1: external INT request level.
- `int_vec_ext` in 8: vector for INT, sampled on the first ack edge.
- `exic` in 8*NUM_EXIC: channel k occupies bits [8k+7:8k].
  - bit7 = request flag (IF).
  - bit6 = mask (MK).
  - bits2:0 = priority, 0 is highest.
- `ie` in 1: CPU interrupt enable.
- `fint` in 1: end-of-interrupt, one ce cycle.
- `int_ack` in 1: CPU acknowledge. Each interrupt takes two pulses.
- `int_req` out 1: interrupt pending to CPU.
- `int_vector` out 8: vector of the granted interrupt.
- `ispr` out 8: in-service priority register.
- `nmi_clear`, `int_clear` out 1: one-clk clear pulses.
- `exic_clear` out NUM_EXIC: one-clk clear pulse per channel.

## Operation
- States:
  - IDLE: no request.
  - PEND: request selected, waiting for first ack.
  - ACK1: first ack seen, waiting for second ack.
- Ack edge: `ack_edge = int_ack & ~ack_prev`. `ack_prev` is registered on every ce cycle.
- Selection in IDLE (on a ce cycle), first match wins:
  1. `nmi` → NMI.
  2. `intp & ie` → INT.
  3. If `ie`: among channels with IF=1, MK=0 and `(ispr & ((2<<prio)-1)) == 0`, take the lowest prio. Ties go to the lowest index.
- On selection, latch the type, channel index and prio, then go to PEND. Later changes on `exic` do not alter the grant.
- PEND + ack_edge:
  - Pulse the matching clear for one clk.
  - Load `int_vector` = NMI_VECTOR / `int_vec_ext` / `VECTOR_BASE+idx`.
  - EXIC grants only: set `ispr[latched prio]`.
  - Go to ACK1.
- ACK1 + ack_edge → IDLE. A new selection can occur on the next ce cycle.
- `fint`: clear the lowest-numbered set ISPR bit, evaluated on the old ISPR, in any state.
- `fint` coinciding with an ISPR set: apply the clear first, then the OR. If it is the same bit, the set wins.
- `int_ack` edges seen in IDLE are ignored. `ack_prev` still updates.

## Timing
- `int_req` is asserted exactly in PEND and ACK1. It asserts one ce cycle after the request is visible in IDLE.
- Clear pulse: the clk after the first ack-edge ce cycle, deasserted on the following clk regardless of `ce`.
- `int_vector` is valid from the cycle after the first ack edge and holds until the next first-ack.
- Reset values:
  - State IDLE.
  - `ispr` = 0, `int_vector` = 0, `ack_prev` = 0.
  - All clears 0; `int_req` = 0.
- Reset mid-handshake: abandon the grant and issue no clear pulse.
- `ce` = 0: state, ISPR and `ack_prev` hold. Clear pulses still self-terminate.

## Structure
- `types` package additions:
  - `pic_state_t` enum (IDLE/PEND/ACK1).
  - `pic_src_t` enum (NMI/INT/EXIC).
  - Constants `EXIC_IF_BIT`=7, `EXIC_MK_BIT`=6, `EXIC_PRIO_LSB`=0.
- One sub-module, `v35_pic_arbiter`:
  - Combinational, parametrised by NUM_EXIC.
  - Inputs: `exic`, `ispr`.
  - Outputs: `valid`, `idx`, `prio`.
- The top level holds the FSM, ISPR and pulse logic.

## Test plan
- Channel 1 prio 5 requesting, ie=1; two ack pulses → `int_req` rises after one ce; on the first ack, `exic_clear`=0b010 for one clk, `int_vector`=25, `ispr`=0x20; `int_req` drops after the second ack.
- Ch0 prio 6 and ch2 prio 2 requesting together → ch2 granted, vector 26, `ispr`=0x04. With ch2 cleared and `ispr`=0x04 still set, ch0 prio 6 is blocked until `fint` clears bit 2.
- `nmi`=1 and `intp`=1 together with ie=0 → NMI granted, vector 2, `nmi_clear` pulsed, `ispr` unchanged.
- `intp`=1, ie=1, `int_vec_ext`=0x40 → vector 0x40, `int_clear` pulsed; `ack` held high for several ce cycles counts as one edge.
- `ispr`=0x0A with `fint` → `ispr`=0x08. `fint` on the same ce as a prio-1 grant → `ispr`=0x0A.
- Reset asserted in ACK1 → `int_req`=0, `ispr`=0, no clear pulse; the next request is granted normally.
